// File: rtl/cntr_n.sv
// Parametrised up/down counter with load, step, wrap/saturate and terminal-count pulse.
// Saturation is only built when CNTR_SAT_EN is defined; otherwise the counter always wraps.
module cntr_n #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    input  logic             sat,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic [2:0]       o_state,
    output logic             tc,
    output logic             zero
);

    localparam logic [2:0] IDLE = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] INC  = 3'b010;
    localparam logic [2:0] DEC  = 3'b100;
    localparam logic [2:0] HOLD = 3'b110;

    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             legal;
    logic [2:0]       state_n;
    logic [WIDTH-1:0] count_n;
    logic             tc_n;

    assign sum    = {1'b0, d_out} + {1'b0, STEP_W};
    assign diff   = d_out - STEP_W;
    assign borrow = d_out < STEP_W;
    assign zero   = (d_out == '0);
    assign legal  = o_state inside {LOAD, INC, DEC, HOLD};

`ifndef CNTR_SAT_EN
    logic unused_sat;
    assign unused_sat = sat;
`endif

    always_comb begin
        state_n = o_state;
        count_n = d_out;
        tc_n    = 1'b0;
        priority case (1'b1)
            clr: begin
                state_n = IDLE;
                count_n = '0;
            end
            load: begin
                state_n = LOAD;
                count_n = d_in;
            end
            (inc && dec): begin
                state_n = HOLD;
            end
            inc: begin
                state_n = INC;
                count_n = sum[WIDTH-1:0];
                tc_n    = sum[WIDTH];
`ifdef CNTR_SAT_EN
                if (sum[WIDTH] && sat)
                    count_n = ALL_ONES;
`endif
            end
            dec: begin
                state_n = DEC;
                count_n = diff;
                tc_n    = borrow;
`ifdef CNTR_SAT_EN
                if (borrow && sat)
                    count_n = '0;
`endif
            end
            default: begin
                // IDLE persists while idle; any illegal code falls back to IDLE
                state_n = legal ? HOLD : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_state <= IDLE;
            d_out   <= '0;
            tc      <= 1'b0;
        end else begin
            o_state <= state_n;
            d_out   <= count_n;
            tc      <= tc_n;
        end
    end

endmodule
